dmem_arbiter: RTL and testbench

- Shares the single-port synchronous dmem between two requesters.
  - Port 0: processor load/store path.
  - Port 1: loader/debug master, used for program/data preload and inspection.
- Sequences each access through a registered issue/wait/respond FSM.
- Round-robin arbitration between the two ports.
- Drives the dmem address/data/wren pins that the top-level wrapper currently connects directly to the processor.

---
 rtl/dmem_arbiter_pkg.sv | 14 +
 rtl/dmem_arbiter_if.sv | 27 ++
 rtl/dmem_arbiter_rr_pick2.sv | 21 ++
 rtl/dmem_arbiter.sv | 132 +++++++++++++
 tb/tb_dmem_arbiter.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and default widths for the dmem arbiter and its requester interface.
package dmem_arbiter_pkg;

    localparam int DMEM_ADDR_W = 12;
    localparam int DMEM_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// One requester's view of the shared dmem: request/address/data in, grant and read response out.
interface dmem_arbiter_if
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DATA_W = DMEM_DATA_W
);

    logic              req;
    logic              wren;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, wren, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, wren, addr, wdata,
        output gnt, rvalid, rdata
    );

endinterface

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone request wins outright, a tie goes to the port
// that was not granted last.
module rr_pick2 (
    input  logic [1:0] i_req,
    input  logic       i_last_grant,
    output logic       o_valid,
    output logic       o_winner
);

    always_comb begin
        o_valid  = |i_req;
        o_winner = 1'b0;
        case (i_req)
            2'b01:   o_winner = 1'b0;
            2'b10:   o_winner = 1'b1;
            2'b11:   o_winner = ~i_last_grant;
            default: o_winner = 1'b0;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port synchronous dmem between the processor (port 0) and the
// loader/debug master (port 1), one access in flight at a time.
//   state    | meaning
//   ST_IDLE  | arbitrate; a winner is latched into the mem pins and gnt is raised
//   ST_ISSUE | mem pins driven, gnt pulse visible, mem_wren high on writes only
//   ST_WAIT  | read in flight, wait counter counting down to 0
//   ST_RESP  | mem_q captured into the winner's rdata, rvalid raised for next cycle
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W   = DMEM_ADDR_W,
    parameter int DATA_W   = DMEM_DATA_W,
    parameter int READ_LAT = 1
) (
    input  logic              i_clock,
    input  logic              i_reset,
    dmem_arbiter_if.slave     port0,
    dmem_arbiter_if.slave     port1,
    output logic [ADDR_W-1:0] o_mem_address,
    output logic [DATA_W-1:0] o_mem_data,
    output logic              o_mem_wren,
    input  logic [DATA_W-1:0] i_mem_q,
    output logic              o_busy
);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic              r_last_grant;
    logic              r_winner;
    logic [1:0]        r_gnt;
    logic [1:0]        r_rvalid;
    logic [1:0]        r_wait_cnt;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;
    logic [ADDR_W-1:0] r_mem_address;
    logic [DATA_W-1:0] r_mem_data;
    logic              r_mem_wren;

    logic [1:0]        w_req;
    logic              w_win_valid;
    logic              w_winner;
    logic              w_sel_wren;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;

    assign w_req = {port1.req, port0.req};

    rr_pick2 u_pick (
        .i_req        (w_req),
        .i_last_grant (r_last_grant),
        .o_valid      (w_win_valid),
        .o_winner     (w_winner)
    );

    assign w_sel_wren  = w_winner ? port1.wren  : port0.wren;
    assign w_sel_addr  = w_winner ? port1.addr  : port0.addr;
    assign w_sel_wdata = w_winner ? port1.wdata : port0.wdata;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    // In ISSUE, r_mem_wren still holds the latched wren of the access being issued.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_win_valid) w_state_nxt = ST_ISSUE;
            ST_ISSUE: w_state_nxt = r_mem_wren ? ST_IDLE : ST_WAIT;
            ST_WAIT:  if (r_wait_cnt == 2'd0) w_state_nxt = ST_RESP;
            ST_RESP:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // The mem pin registers double as the issue register and hold between accesses.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_last_grant  <= 1'b1;
            r_winner      <= 1'b0;
            r_gnt         <= 2'b00;
            r_rvalid      <= 2'b00;
            r_wait_cnt    <= 2'd0;
            r_rdata0      <= '0;
            r_rdata1      <= '0;
            r_mem_address <= '0;
            r_mem_data    <= '0;
            r_mem_wren    <= 1'b0;
        end else begin
            r_gnt      <= 2'b00;
            r_rvalid   <= 2'b00;
            r_mem_wren <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_win_valid) begin
                        r_winner        <= w_winner;
                        r_last_grant    <= w_winner;
                        r_gnt[w_winner] <= 1'b1;
                        r_mem_address   <= w_sel_addr;
                        r_mem_data      <= w_sel_wdata;
                        r_mem_wren      <= w_sel_wren;
                    end
                end
                ST_ISSUE: begin
                    if (!r_mem_wren) r_wait_cnt <= 2'(READ_LAT - 1);
                end
                ST_WAIT: begin
                    if (r_wait_cnt != 2'd0) r_wait_cnt <= r_wait_cnt - 2'd1;
                end
                ST_RESP: begin
                    r_rvalid[r_winner] <= 1'b1;
                    if (r_winner) r_rdata1 <= i_mem_q;
                    else          r_rdata0 <= i_mem_q;
                end
                default: ;
            endcase
        end
    end

    assign port0.gnt    = r_gnt[0];
    assign port1.gnt    = r_gnt[1];
    assign port0.rvalid = r_rvalid[0];
    assign port1.rvalid = r_rvalid[1];
    assign port0.rdata  = r_rdata0;
    assign port1.rdata  = r_rdata1;

    assign o_mem_address = r_mem_address;
    assign o_mem_data    = r_mem_data;
    assign o_mem_wren    = r_mem_wren;
    assign o_busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: one READ_LAT=1 and one READ_LAT=3 instance, each
// on its own behavioural dmem, read data checked against a per-port expected queue.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    localparam int SEL_GNT0 = 0, SEL_GNT1 = 1, SEL_GNT30 = 2;
    localparam int SEL_RV0  = 3, SEL_RV1  = 4, SEL_RV30  = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dmem_arbiter_if bus0 ();
    dmem_arbiter_if bus1 ();
    dmem_arbiter_if bus30 ();
    dmem_arbiter_if bus31 ();

    logic [11:0] mem_address1, mem_address3;
    logic [31:0] mem_data1, mem_data3, mem_q1, mem_q3;
    logic        mem_wren1, mem_wren3, busy1, busy3;

    dmem_arbiter #(.READ_LAT(1)) u_dut (
        .i_clock       (clk),
        .i_reset       (rst),
        .port0         (bus0),
        .port1         (bus1),
        .o_mem_address (mem_address1),
        .o_mem_data    (mem_data1),
        .o_mem_wren    (mem_wren1),
        .i_mem_q       (mem_q1),
        .o_busy        (busy1)
    );

    dmem_arbiter #(.READ_LAT(3)) u_dut3 (
        .i_clock       (clk),
        .i_reset       (rst),
        .port0         (bus30),
        .port1         (bus31),
        .o_mem_address (mem_address3),
        .o_mem_data    (mem_data3),
        .o_mem_wren    (mem_wren3),
        .i_mem_q       (mem_q3),
        .o_busy        (busy3)
    );

    // Unwritten dmem locations read back a pattern derived from the address.
    function automatic logic [31:0] pattern(input logic [11:0] a);
        return {20'hA5C30, a};
    endfunction

    bit   [31:0] mem1 [int unsigned];
    bit   [31:0] mem3 [int unsigned];
    logic [31:0] q3a, q3b;

    always @(posedge clk) begin
        mem_q1 <= mem1.exists(32'(mem_address1)) ? mem1[32'(mem_address1)] : pattern(mem_address1);
        if (mem_wren1) mem1[32'(mem_address1)] = mem_data1;
    end

    always @(posedge clk) begin
        q3a    <= mem3.exists(32'(mem_address3)) ? mem3[32'(mem_address3)] : pattern(mem_address3);
        q3b    <= q3a;
        mem_q3 <= q3b;
        if (mem_wren3) mem3[32'(mem_address3)] = mem_data3;
    end

    int tests = 0;
    int fails = 0;
    logic [31:0] q_exp0[$];
    logic [31:0] q_exp1[$];
    logic [31:0] q_exp3[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            SEL_GNT0:  return bus0.gnt;
            SEL_GNT1:  return bus1.gnt;
            SEL_GNT30: return bus30.gnt;
            SEL_RV0:   return bus0.rvalid;
            SEL_RV1:   return bus1.rvalid;
            SEL_RV30:  return bus30.rvalid;
            default:   return 1'b0;
        endcase
    endfunction

    // n = cycles until the selected pulse is seen, 0 if the budget runs out.
    task automatic wait_sig(input int sel, input int limit, output int n);
        n = 0;
        for (int k = 1; k <= limit; k++) begin
            tick();
            if (sig(sel)) begin
                n = k;
                break;
            end
        end
    endtask

    // who: 0/1 for a single grant, 2 for both at once, -1 on timeout.
    task automatic wait_any_gnt(output int who, output int n);
        who = -1;
        n   = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (bus0.gnt || bus1.gnt) begin
                n   = k;
                who = (bus0.gnt && bus1.gnt) ? 2 : (bus1.gnt ? 1 : 0);
                break;
            end
        end
    endtask

    // Scoreboard: every rvalid must match the oldest expected word for that port.
    always @(negedge clk) begin
        if (bus0.rvalid) begin
            if (q_exp0.size() == 0) check("rvalid0_spurious", bus0.rvalid, 1'b0);
            else                    check("rdata0", bus0.rdata, q_exp0.pop_front());
        end
        if (bus1.rvalid) begin
            if (q_exp1.size() == 0) check("rvalid1_spurious", bus1.rvalid, 1'b0);
            else                    check("rdata1", bus1.rdata, q_exp1.pop_front());
        end
        if (bus30.rvalid) begin
            if (q_exp3.size() == 0) check("rvalid30_spurious", bus30.rvalid, 1'b0);
            else                    check("rdata30", bus30.rdata, q_exp3.pop_front());
        end
        if (bus31.rvalid) check("rvalid31_spurious", bus31.rvalid, 1'b0);
    end

    initial begin
        int   n;
        int   who;
        logic saw;

        rst = 1'b1;
        bus0.req  = 1'b0; bus0.wren  = 1'b0; bus0.addr  = '0; bus0.wdata  = '0;
        bus1.req  = 1'b0; bus1.wren  = 1'b0; bus1.addr  = '0; bus1.wdata  = '0;
        bus30.req = 1'b0; bus30.wren = 1'b0; bus30.addr = '0; bus30.wdata = '0;
        bus31.req = 1'b0; bus31.wren = 1'b0; bus31.addr = '0; bus31.wdata = '0;
        tick();
        tick();
        check("reset_ctrl", {bus0.gnt, bus1.gnt, bus0.rvalid, bus1.rvalid, busy1, mem_wren1}, 6'b0);
        check("reset_mem_bus", {mem_address1, mem_data1}, 44'h0);
        check("reset_rdata", {bus0.rdata, bus1.rdata}, 64'h0);
        rst = 1'b0;
        tick();

        // Port 0 write
        bus0.req = 1'b1; bus0.wren = 1'b1; bus0.addr = 12'h010; bus0.wdata = 32'hDEADBEEF;
        wait_sig(SEL_GNT0, 8, n);
        check("wr_gnt0_latency", n, 1);
        check("wr_issue_pins", {mem_wren1, mem_address1, mem_data1}, {1'b1, 12'h010, 32'hDEADBEEF});
        check("wr_issue_busy", {busy1, bus1.gnt}, 2'b10);
        bus0.req = 1'b0; bus0.wren = 1'b0;
        tick();
        check("wr_back_idle", {busy1, mem_wren1, bus0.gnt}, 3'b000);
        check("wr_addr_hold", mem_address1, 12'h010);

        // Port 1 reads back the word port 0 wrote
        q_exp1.push_back(32'hDEADBEEF);
        bus1.req = 1'b1; bus1.wren = 1'b0; bus1.addr = 12'h010;
        wait_sig(SEL_GNT1, 8, n);
        check("rd1_gnt_latency", n, 1);
        bus1.req = 1'b0;
        wait_sig(SEL_RV1, 12, n);
        check("rd1_rvalid_latency", n, 3);
        check("rd1_rvalid0_quiet", bus0.rvalid, 1'b0);

        // Both ports hold read requests: grants must alternate starting with port 0
        q_exp0.push_back(pattern(12'h020)); q_exp0.push_back(pattern(12'h021));
        q_exp1.push_back(pattern(12'h031)); q_exp1.push_back(pattern(12'h032));
        bus0.req = 1'b1; bus0.addr = 12'h020;
        bus1.req = 1'b1; bus1.addr = 12'h031;
        for (int g = 0; g < 4; g++) begin
            wait_any_gnt(who, n);
            check("alt_grant_order", who, g % 2);
            if (who == 0)      bus0.addr = 12'h021;
            else if (who == 1) bus1.addr = 12'h032;
        end
        bus0.req = 1'b0; bus1.req = 1'b0;
        n = 0;
        while ((q_exp0.size() + q_exp1.size()) != 0 && n < 30) begin
            tick();
            n++;
        end
        check("alt_drained", q_exp0.size() + q_exp1.size(), 0);

        // READ_LAT=3 instance
        q_exp3.push_back(pattern(12'h0AB));
        bus30.req = 1'b1; bus30.wren = 1'b0; bus30.addr = 12'h0AB;
        wait_sig(SEL_GNT30, 8, n);
        check("lat3_gnt_latency", n, 1);
        bus30.req = 1'b0;
        saw = 1'b0;
        n = 0;
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (mem_wren3) saw = 1'b1;
            if (bus30.rvalid) begin
                n = k;
                break;
            end
        end
        check("lat3_rvalid_latency", n, 5);
        check("lat3_no_wren_in_wait", saw, 1'b0);

        // Reset while a port 0 read sits in WAIT
        bus0.req = 1'b1; bus0.wren = 1'b0; bus0.addr = 12'h020;
        wait_sig(SEL_GNT0, 8, n);
        check("rst_rd_gnt_latency", n, 1);
        bus0.req = 1'b0;
        tick();
        check("rst_in_wait_busy", busy1, 1'b1);
        rst = 1'b1;
        #1;
        check("rst_async_ctrl", {bus0.gnt, bus1.gnt, bus0.rvalid, bus1.rvalid, busy1, mem_wren1}, 6'b0);
        check("rst_async_bus", {mem_address1, mem_data1}, 44'h0);
        check("rst_async_rdata", {bus0.rdata, bus1.rdata}, 64'h0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        tick();

        // First access after reset is a tie: port 0 must win, then port 1
        q_exp0.push_back(pattern(12'h024));
        q_exp1.push_back(pattern(12'h035));
        bus0.req = 1'b1; bus0.addr = 12'h024;
        bus1.req = 1'b1; bus1.addr = 12'h035;
        wait_any_gnt(who, n);
        check("post_rst_first_gnt", who, 0);
        check("post_rst_first_latency", n, 1);
        bus0.req = 1'b0;
        wait_any_gnt(who, n);
        check("post_rst_second_gnt", who, 1);
        bus1.req = 1'b0;
        wait_sig(SEL_RV1, 12, n);
        check("post_rst_rvalid1_latency", n, 3);

        // Port 0 raises req while busy, then drops it as port 1 raises req in IDLE
        q_exp1.push_back(pattern(12'h036));
        bus1.req = 1'b1; bus1.wren = 1'b0; bus1.addr = 12'h036;
        wait_sig(SEL_GNT1, 8, n);
        check("drop_setup_gnt1", n, 1);
        bus1.req = 1'b0;
        bus0.req = 1'b1; bus0.wren = 1'b0; bus0.addr = 12'h040;
        tick();
        tick();
        tick();
        check("drop_idle_reached", busy1, 1'b0);
        bus0.req = 1'b0;
        bus1.req = 1'b1; bus1.wren = 1'b1; bus1.addr = 12'h050; bus1.wdata = 32'hCAFEF00D;
        tick();
        check("drop_only_gnt1", {bus0.gnt, bus1.gnt}, 2'b01);
        bus1.req = 1'b0; bus1.wren = 1'b0;
        saw = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (bus0.gnt) saw = 1'b1;
        end
        check("drop_no_gnt0", saw, 1'b0);

        // Port 0 reads back port 1's write
        q_exp0.push_back(32'hCAFEF00D);
        bus0.req = 1'b1; bus0.wren = 1'b0; bus0.addr = 12'h050;
        wait_sig(SEL_GNT0, 8, n);
        check("rd0_gnt_latency", n, 1);
        bus0.req = 1'b0;
        wait_sig(SEL_RV0, 12, n);
        check("rd0_rvalid_latency", n, 3);

        tick();
        tick();
        check("scoreboard_empty", q_exp0.size() + q_exp1.size() + q_exp3.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
